// File: rtl/leon_inst_feeder_if.sv
// Instruction load and fetch handshake bundle between the bench/IU and the feeder.
interface leon_inst_feeder_if;
    logic        load_valid;
    logic [31:0] load_inst;
    logic        load_ready;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_hold;
    logic        fetch_valid;
    logic [31:0] fetch_data;

    // Driver side: the bench loading words and the IU issuing fetches.
    modport master (
        output load_valid, load_inst, fetch_req, fetch_addr,
        input  load_ready, fetch_hold, fetch_valid, fetch_data
    );

    // Feeder side.
    modport slave (
        input  load_valid, load_inst, fetch_req, fetch_addr,
        output load_ready, fetch_hold, fetch_valid, fetch_data
    );
endinterface

// File: rtl/leon_inst_feeder.sv
// Instruction-side stimulus stage: queues instruction words and answers IU fetches
// after a fixed wait-state latency, substituting a NOP on underrun and checking
// that fetch addresses run sequentially.
module leon_inst_feeder #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned LATENCY  = 2,
    parameter logic [31:0] NOP_INST = 32'h01000000,
    parameter logic [31:0] RST_PC   = 32'h00000000,
    parameter int unsigned UCNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    leon_inst_feeder_if.slave          bus,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [UCNT_W-1:0]          underrun_cnt,
    output logic                       addr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [3:0]  LAT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    logic [31:0]       r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_load_ready;

    state_t            r_state;
    logic [3:0]        r_wcnt;
    logic              r_src;
    logic [31:0]       r_acc_addr;
    logic [31:0]       r_exp_pc;
    logic              r_fetch_hold;
    logic              r_fetch_valid;
    logic [31:0]       r_fetch_data;
    logic [UCNT_W-1:0] r_ucnt;
    logic              r_addr_err;

    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_count_nxt;
    logic [31:0]       w_resp_word;

    assign w_push      = bus.load_valid && r_load_ready;
    assign w_pop       = (r_state == S_RESP) && r_src;
    // Head is stable from accept to response: pops only happen in RESP.
    assign w_resp_word = (r_count != CW'(0)) ? r_mem[r_rd_ptr] : NOP_INST;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= bus.load_inst;
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_load_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count      <= w_count_nxt;
            r_load_ready <= (w_count_nxt != CW'(DEPTH));
        end
    end

    // Fetch FSM: accept, wait-state countdown, one-cycle response, PC tracking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_wcnt        <= '0;
            r_src         <= 1'b0;
            r_acc_addr    <= '0;
            r_exp_pc      <= RST_PC;
            r_fetch_hold  <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= '0;
            r_ucnt        <= '0;
            r_addr_err    <= 1'b0;
        end else begin
            r_fetch_hold  <= 1'b0;
            r_fetch_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.fetch_req) begin
                        r_src      <= (r_count != CW'(0));
                        r_acc_addr <= bus.fetch_addr;
                        if (bus.fetch_addr != r_exp_pc) begin
                            r_addr_err <= 1'b1;
                        end
                        if (LATENCY == 0) begin
                            r_state       <= S_RESP;
                            r_fetch_valid <= 1'b1;
                            r_fetch_data  <= w_resp_word;
                        end else begin
                            r_state      <= S_WAIT;
                            r_wcnt       <= LAT_INIT;
                            r_fetch_hold <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        r_state       <= S_RESP;
                        r_fetch_valid <= 1'b1;
                        r_fetch_data  <= r_src ? r_mem[r_rd_ptr] : NOP_INST;
                    end else begin
                        r_wcnt       <= r_wcnt - 4'd1;
                        r_fetch_hold <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_exp_pc <= r_acc_addr + 32'd4;
                    if (!r_src && (r_ucnt != {UCNT_W{1'b1}})) begin
                        r_ucnt <= r_ucnt + UCNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.load_ready  = r_load_ready;
    assign bus.fetch_hold  = r_fetch_hold;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.fetch_data  = r_fetch_data;
    assign fifo_count      = r_count;
    assign underrun_cnt    = r_ucnt;
    assign addr_err        = r_addr_err;

endmodule

// File: tb/tb_leon_inst_feeder.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model; a second instance covers zero latency and saturation.
module tb_leon_inst_feeder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] NOP   = 32'h01000000;
    localparam logic [31:0] RPC   = 32'h00000000;

    logic clk;
    logic rst;
    logic rst_b;

    leon_inst_feeder_if bus_a ();
    leon_inst_feeder_if bus_b ();

    logic [4:0]  cnt_a;
    logic [15:0] ucnt_a;
    logic        err_a;
    logic [4:0]  cnt_b;
    logic [3:0]  ucnt_b;
    logic        err_b;

    leon_inst_feeder #(.DEPTH(DEPTH), .LATENCY(LAT), .NOP_INST(NOP), .RST_PC(RPC), .UCNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .fifo_count(cnt_a), .underrun_cnt(ucnt_a), .addr_err(err_a)
    );

    leon_inst_feeder #(.DEPTH(DEPTH), .LATENCY(0), .NOP_INST(NOP), .RST_PC(RPC), .UCNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b),
        .fifo_count(cnt_b), .underrun_cnt(ucnt_b), .addr_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference model of instance A.
    logic [31:0] m_q[$];
    bit          m_busy;
    int          m_acc_edge;
    bit          m_src;
    logic [31:0] m_acc;
    logic [31:0] m_exp_pc;
    int          m_ucnt;
    bit          m_err;
    logic [31:0] m_data;
    int          edge_n = 0;

    task automatic model_edge(input logic rv, input logic lv, input logic [31:0] li,
                              input logic fr, input logic [31:0] fa);
        int cnt0;
        cnt0 = m_q.size();
        if (!rv) begin
            m_q.delete();
            m_busy   = 1'b0;
            m_exp_pc = RPC;
            m_ucnt   = 0;
            m_err    = 1'b0;
            m_data   = '0;
            return;
        end
        if (m_busy && edge_n == m_acc_edge + int'(LAT) + 1) begin
            if (m_src) void'(m_q.pop_front());
            else if (m_ucnt < 65535) m_ucnt++;
            m_exp_pc = m_acc + 32'd4;
            m_busy   = 1'b0;
        end else if (!m_busy && fr) begin
            m_busy     = 1'b1;
            m_acc_edge = edge_n;
            m_src      = (cnt0 != 0);
            m_acc      = fa;
            if (fa != m_exp_pc) m_err = 1'b1;
        end
        if (lv && cnt0 != int'(DEPTH)) m_q.push_back(li);
        if (m_busy && edge_n == m_acc_edge + int'(LAT)) m_data = m_src ? m_q[0] : NOP;
    endtask

    // One clock of instance A: drive, update the model at the edge, compare at negedge.
    task automatic step(input logic rv, input logic lv, input logic [31:0] li,
                        input logic fr, input logic [31:0] fa);
        bit exp_valid;
        bit exp_hold;
        rst              = rv;
        bus_a.load_valid = lv;
        bus_a.load_inst  = li;
        bus_a.fetch_req  = fr;
        bus_a.fetch_addr = fa;
        @(posedge clk);
        model_edge(rv, lv, li, fr, fa);
        @(negedge clk);
        exp_valid = m_busy && (edge_n == m_acc_edge + int'(LAT));
        exp_hold  = m_busy && (edge_n <  m_acc_edge + int'(LAT));
        check_eq("fetch_valid", 32'(bus_a.fetch_valid), 32'(exp_valid));
        check_eq("fetch_hold",  32'(bus_a.fetch_hold),  32'(exp_hold));
        check_eq("fetch_data",  bus_a.fetch_data,       m_data);
        check_eq("load_ready",  32'(bus_a.load_ready),  32'(m_q.size() != int'(DEPTH)));
        check_eq("fifo_count",  32'(cnt_a),             32'(m_q.size()));
        check_eq("underrun",    32'(ucnt_a),            32'(m_ucnt));
        check_eq("addr_err",    32'(err_a),             32'(m_err));
        edge_n++;
    endtask

    task automatic idle_a(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic reset_a();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic push_a(input logic [31:0] w);
        step(1'b1, 1'b1, w, 1'b0, 32'h0);
    endtask

    task automatic fetch_a(input logic [31:0] a);
        step(1'b1, 1'b0, 32'h0, 1'b1, a);
        idle_a(int'(LAT) + 1);
    endtask

    initial begin
        logic [31:0] a;
        rst = 1'b0;
        rst_b = 1'b0;
        bus_a.load_valid = 1'b0; bus_a.load_inst = '0; bus_a.fetch_req = 1'b0; bus_a.fetch_addr = '0;
        bus_b.load_valid = 1'b0; bus_b.load_inst = '0; bus_b.fetch_req = 1'b0; bus_b.fetch_addr = '0;

        // In-order delivery of three queued words.
        reset_a();
        reset_a();
        check_eq("rst_data", bus_a.fetch_data, 32'h0);
        push_a(32'h82102005);
        push_a(32'h01000000);
        push_a(32'h84004001);
        check_eq("t1_cnt3", 32'(cnt_a), 32'd3);
        fetch_a(32'h0);
        check_eq("t1_w0", bus_a.fetch_data, 32'h82102005);
        fetch_a(32'h4);
        fetch_a(32'h8);
        check_eq("t1_w2", bus_a.fetch_data, 32'h84004001);
        check_eq("t1_cnt0", 32'(cnt_a), 32'd0);

        // Underrun decided at accept; a push during WAIT does not change it.
        reset_a();
        step(1'b1, 1'b0, 32'h0, 1'b1, RPC);
        push_a(32'hDEADBEEF);
        idle_a(2);
        check_eq("t2_nop", bus_a.fetch_data, NOP);
        check_eq("t2_ucnt", 32'(ucnt_a), 32'd1);
        check_eq("t2_cnt", 32'(cnt_a), 32'd1);

        // Fill to full, overflow word dropped, ready returns after the pop.
        reset_a();
        for (int i = 0; i < 17; i++) push_a(32'h1000 + 32'(i));
        check_eq("t3_full", 32'(bus_a.load_ready), 32'd0);
        fetch_a(32'h0);
        check_eq("t3_head", bus_a.fetch_data, 32'h1000);
        check_eq("t3_cnt", 32'(cnt_a), 32'd15);

        // Sticky address error and resynchronisation.
        reset_a();
        fetch_a(32'h0);
        fetch_a(32'h4);
        check_eq("t4_ok", 32'(err_a), 32'd0);
        fetch_a(32'h40);
        fetch_a(32'h44);
        check_eq("t4_err", 32'(err_a), 32'd1);

        // Reset during WAIT drops the response.
        push_a(32'hCAFE0001);
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h48);
        reset_a();
        idle_a(3);
        fetch_a(RPC);
        check_eq("t5_nop", bus_a.fetch_data, NOP);
        check_eq("t5_err", 32'(err_a), 32'd0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            a = ($urandom_range(0, 9) == 0) ? ($urandom() & 32'hFFFF_FFFC) : m_exp_pc;
            step(($urandom_range(0, 499) != 0), ($urandom_range(0, 1) == 1), $urandom(),
                 ($urandom_range(0, 4) < 2), a);
        end

        // Zero-latency instance with a 4-bit saturating underrun counter.
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_b = 1'b1;
        check_eq("b_rst_ucnt", 32'(ucnt_b), 32'd0);
        for (int k = 1; k <= 20; k++) begin
            bus_b.fetch_req  = 1'b1;
            bus_b.fetch_addr = 32'(k - 1) * 32'd4;
            @(posedge clk); @(negedge clk);
            bus_b.fetch_req = 1'b0;
            check_eq("b_valid", 32'(bus_b.fetch_valid), 32'd1);
            check_eq("b_hold", 32'(bus_b.fetch_hold), 32'd0);
            check_eq("b_data", bus_b.fetch_data, NOP);
            @(posedge clk); @(negedge clk);
            check_eq("b_valid_off", 32'(bus_b.fetch_valid), 32'd0);
            check_eq("b_ucnt", 32'(ucnt_b), (k > 15) ? 32'd15 : 32'(k));
        end
        check_eq("b_err", 32'(err_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
